// File: rtl/ts_capture_buf.sv
// Timestamp capture buffer: free-running 32-bit tick counter, rising-edge event
// capture into a 32-entry circular buffer, oldest-first indexed registered reads.
module ts_capture_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        event_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [4:0]  ts_addr_i,
  output logic [31:0] ts_data_o,
  output logic [5:0]  count_o,
  output logic        overflow_o,
  output logic [31:0] tick_o
);

  logic [31:0] tick_q;
  logic        event_q;
  logic [4:0]  wr_ptr_q;
  logic [5:0]  count_q;
  logic        ovf_q;
  logic [31:0] rd_q;
  logic [31:0] mem [0:31];

  logic        full;
  logic        capture;
  logic [4:0]  oldest;
  logic [4:0]  rd_idx;
  logic        addr_valid;

  assign full       = (count_q == 6'd32);
  // Clear and reset both win over a coincident capture.
  assign capture    = event_i & ~event_q & enable_i & ~clear_i & ~rst_i;
  assign oldest     = full ? wr_ptr_q : 5'd0;
  assign rd_idx     = oldest + ts_addr_i;
  assign addr_valid = ({1'b0, ts_addr_i} < count_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q   <= 32'd0;
      event_q  <= 1'b0;
      wr_ptr_q <= 5'd0;
      count_q  <= 6'd0;
      ovf_q    <= 1'b0;
    end else begin
      tick_q  <= tick_q + 32'd1;
      event_q <= event_i;
      if (clear_i) begin
        wr_ptr_q <= 5'd0;
        count_q  <= 6'd0;
        ovf_q    <= 1'b0;
      end else if (capture) begin
        wr_ptr_q <= wr_ptr_q + 5'd1;
        if (full) ovf_q   <= 1'b1;
        else      count_q <= count_q + 6'd1;
      end
    end
  end

  // Array has no reset so it maps onto a plain 1W/1R synchronous RAM.
  always_ff @(posedge clk_i) begin
    if (capture) mem[wr_ptr_q] <= tick_q;
  end

  // Read is request-in-cycle-N, data-after-edge-N; it sees pre-edge state,
  // so a coincident capture only becomes visible to the following read.
  always_ff @(posedge clk_i) begin
    if (rst_i)           rd_q <= 32'd0;
    else if (addr_valid) rd_q <= mem[rd_idx];
    else                 rd_q <= 32'd0;
  end

  assign ts_data_o  = rd_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign tick_o     = tick_q;

endmodule
